button_bounce_emulator: RTL
===========================

Name: button_bounce_emulator

Overview:
- Generates a realistic bouncy push-button waveform from a single-cycle press request. Lab input debouncers are driven with it on the board and in simulation.
- Sequence per press: pseudo-random chatter, clean high hold, pseudo-random release chatter, then low.
- Sits upstream of the debouncer. Its button_out feeds the debouncer's button_in.

Parameters:
- BOUNCE_CYCLES, 64: length of each chatter phase in clk cycles (>=1).
- HOLD_CYCLES, 20000: clean-high phase length in clk cycles (>=1). Set it above the downstream debounce threshold.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  press request; sampled only in IDLE
- abort  input  1  cancel current press; highest priority after reset
- button_out  output  1  emulated raw button level, registered
- busy  output  1  high while a press sequence is in progress
- done  output  1  one-cycle pulse when a sequence completes normally

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and reset_n.
- All outputs are registered.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, phase counter=0, LFSR=SEED (or 16'hACE1 if SEED==0).
  - button_out=0, busy=0, done=0.
- States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE.
- IDLE:
  - button_out=0, busy=0.
  - start=1 at edge k -> PRESS_BOUNCE from cycle k+1, with busy=1 and counter=0.
- PRESS_BOUNCE:
  - button_out = LFSR bit0 each cycle.
  - LFSR advances one step per cycle.
  - Lasts exactly BOUNCE_CYCLES cycles, then -> HOLD.
- HOLD:
  - button_out=1 for exactly HOLD_CYCLES cycles, then -> RELEASE_BOUNCE.
  - LFSR frozen.
- RELEASE_BOUNCE:
  - Same as PRESS_BOUNCE for BOUNCE_CYCLES cycles.
  - Then -> IDLE with button_out=0, busy=0, and done=1 for that single cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit0.
  - It advances only in the bounce states, so the sequence is deterministic across presses from reset.
  - It is never reset by start.
- Phase counter:
  - Width $clog2(max(BOUNCE_CYCLES,HOLD_CYCLES)+1).
  - Counts 0..N-1 per phase and clears on every state transition.
- Busy handling: start while busy is ignored; it is not queued.
  - start on the same cycle done is asserted is accepted, because the state is IDLE then.
  - That gives back-to-back presses with exactly one IDLE cycle between them.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, button_out=0, busy=0, done=0. Counter cleared, LFSR retains its value.
  - abort in IDLE has no effect.
  - abort and start together in IDLE -> stay IDLE.
- Reset mid-sequence: immediate return to the reset values above; no done pulse.

Optional Feature:
- Macro BOUNCE_EMU_PRESS_COUNT_EN.
- When defined:
  - Adds output press_count [7:0], reset 0.
  - Increments on each done pulse; wraps 255->0.
  - abort does not increment it.
- When undefined: the port and its logic are absent. Remaining behaviour is identical.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=2'd0, PRESS_BOUNCE=2'd1, HOLD=2'd2, RELEASE_BOUNCE=2'd3);
  - default LFSR seed constant 16'hACE1;
  - LFSR tap mask 16'hB400.
- One natural sub-module, lfsr16: inputs clk, reset_n, advance; parameter SEED; output q[15:0].

Test Plan:
- Nominal timing, BOUNCE_CYCLES=8, HOLD_CYCLES=20, start pulse at cycle 10:
  - busy=1 cycles 11..46; button_out=1 on every cycle 19..38.
  - done=1 only at cycle 47.
- Determinism, SEED=16'hACE1:
  - The first 8 button_out values of PRESS_BOUNCE match the reference LFSR bit0 sequence computed in the bench.
  - The same seed after a second reset reproduces the same sequence.
- Start while busy: start pulsed at cycles 10 and 25 -> a single sequence, done once at cycle 47.
- Back-to-back: start held at 1 continuously -> second busy rises at cycle 48 and done pulses every 37 cycles.
- Abort: abort=1 at cycle 30 (HOLD) -> cycle 31 button_out=0, busy=0; no done. A later start begins a fresh sequence.
- Reset mid-HOLD: reset_n low at cycle 30 -> button_out/busy/done go 0 asynchronously and the LFSR returns to 16'hACE1.
  - With BOUNCE_EMU_PRESS_COUNT_EN defined: press_count=0 after reset, and 256 completed presses wrap it back to 0.

Source files
------------

// File: rtl/button_bounce_emulator_pkg.sv
// rtl/button_bounce_emulator_pkg.sv - shared state encoding and LFSR constants for the bounce emulator
package button_bounce_emulator_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HOLD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;

    // Fibonacci step: taps 16,14,13,11 (bits 15,13,12,10), shift left, feedback into bit0
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/button_bounce_emulator_lfsr16.sv
// rtl/button_bounce_emulator_lfsr16.sv - 16-bit Fibonacci LFSR that steps only when advance is high
module lfsr16
    import button_bounce_emulator_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    output logic [15:0] q
);

    // An all-zero state would lock up the LFSR, so a zero seed falls back to the default
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (advance) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/button_bounce_emulator.sv
// rtl/button_bounce_emulator.sv - bouncy push-button waveform generator; optional BOUNCE_EMU_PRESS_COUNT_EN adds press_count
module button_bounce_emulator
    import button_bounce_emulator_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned HOLD_CYCLES   = 20000,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       button_out,
    output logic       busy,
`ifdef BOUNCE_EMU_PRESS_COUNT_EN
    output logic       done,
    output logic [7:0] press_count
`else
    output logic       done
`endif
);

    localparam int unsigned MAX_CYCLES = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             button_out_q, button_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lfsr_advance;
    logic [15:0]      lfsr_q;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .advance(lfsr_advance),
        .q      (lfsr_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    state_d = PRESS_BOUNCE;
                end
            end
            PRESS_BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE_BOUNCE;
                end
            end
            RELEASE_BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are registered from the next state so they line up with it cycle for cycle
        lfsr_advance = (state_d == PRESS_BOUNCE) || (state_d == RELEASE_BOUNCE);
        busy_d       = (state_d != IDLE);
        if (state_d == HOLD) begin
            button_out_d = 1'b1;
        end else if (lfsr_advance) begin
            button_out_d = lfsr_q[0];
        end else begin
            button_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            button_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            button_out_q <= button_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign button_out = button_out_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef BOUNCE_EMU_PRESS_COUNT_EN
    logic [7:0] press_count_q, press_count_d;

    always_comb begin
        press_count_d = press_count_q;
        if (done_d) begin
            press_count_d = press_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count_q <= 8'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign press_count = press_count_q;
`endif

endmodule
